// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable first-word-fall-through or registered read,
// occupancy count, programmable almost-full/almost-empty thresholds, synchronous
// flush and one-cycle overflow/underflow pulses.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter bit FWFT          = 1'b0,
  parameter int AF_THRESH     = (2 ** ADDRESS_WIDTH) - 2,
  parameter int AE_THRESH     = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic                    W_INC,
  input  logic [DATA_WIDTH-1:0]   Wr_DATA,
  input  logic                    R_INC,
  output logic [DATA_WIDTH-1:0]   Rd_DATA,
  output logic                    Rd_VALID,
  output logic                    FULL,
  output logic                    EMPTY,
  output logic                    ALMOST_FULL,
  output logic                    ALMOST_EMPTY,
  output logic [ADDRESS_WIDTH:0]  FILL_LEVEL,
  output logic                    OVERFLOW,
  output logic                    UNDERFLOW
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] AF_LVL = (ADDRESS_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDRESS_WIDTH:0] AE_LVL = (ADDRESS_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDRESS_WIDTH:0] wptr;
  logic [ADDRESS_WIDTH:0] rptr;
  logic                   wr_acc;
  logic                   rd_acc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign EMPTY        = (wptr == rptr);
  assign FULL         = (wptr[ADDRESS_WIDTH] != rptr[ADDRESS_WIDTH]) &&
                        (wptr[ADDRESS_WIDTH-1:0] == rptr[ADDRESS_WIDTH-1:0]);
  assign FILL_LEVEL   = wptr - rptr;
  assign ALMOST_FULL  = (FILL_LEVEL >= AF_LVL);
  assign ALMOST_EMPTY = (FILL_LEVEL <= AE_LVL);

  // Acceptance uses this cycle's flags: a read never frees room for a same-cycle write.
  assign wr_acc = W_INC & ~FULL & ~FLUSH;
  assign rd_acc = R_INC & ~EMPTY & ~FLUSH;

  // Storage array, deliberately without reset.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wptr[ADDRESS_WIDTH-1:0]] <= Wr_DATA;
  end

  // Pointer update; flush returns both to zero ahead of any request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr <= '0;
      rptr <= '0;
    end else if (FLUSH) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // Refused-request pulses, one cycle after the offending request.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= W_INC & FULL & ~FLUSH;
      UNDERFLOW <= R_INC & EMPTY & ~FLUSH;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is always presented; R_INC acknowledges it.
      assign Rd_DATA  = mem[rptr[ADDRESS_WIDTH-1:0]];
      assign Rd_VALID = ~EMPTY;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // Registered read: data captured on an accepted read, held otherwise.
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem[rptr[ADDRESS_WIDTH-1:0]];
        end
      end

      assign Rd_DATA  = rd_data_q;
      assign Rd_VALID = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: a registered-read and a fall-through instance share
// one stimulus stream; a queue-based reference model predicts every output.
module tb_sync_fifo_fwft;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          w_inc;
  logic [DW-1:0] wr_data;
  logic          r_inc;

  logic [DW-1:0] r_rd_data, f_rd_data;
  logic          r_rd_valid, f_rd_valid;
  logic          r_full, f_full, r_empty, f_empty;
  logic          r_af, f_af, r_ae, f_ae;
  logic [AW:0]   r_level, f_level;
  logic          r_ovf, f_ovf, r_unf, f_unf;

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(1'b0)) u_reg (
    .CLK(clk), .RST(rst_n), .FLUSH(flush), .W_INC(w_inc), .Wr_DATA(wr_data),
    .R_INC(r_inc), .Rd_DATA(r_rd_data), .Rd_VALID(r_rd_valid), .FULL(r_full),
    .EMPTY(r_empty), .ALMOST_FULL(r_af), .ALMOST_EMPTY(r_ae),
    .FILL_LEVEL(r_level), .OVERFLOW(r_ovf), .UNDERFLOW(r_unf));

  sync_fifo_fwft #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FWFT(1'b1)) u_fw (
    .CLK(clk), .RST(rst_n), .FLUSH(flush), .W_INC(w_inc), .Wr_DATA(wr_data),
    .R_INC(r_inc), .Rd_DATA(f_rd_data), .Rd_VALID(f_rd_valid), .FULL(f_full),
    .EMPTY(f_empty), .ALMOST_FULL(f_af), .ALMOST_EMPTY(f_ae),
    .FILL_LEVEL(f_level), .OVERFLOW(f_ovf), .UNDERFLOW(f_unf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a plain queue, plus expected pulses.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic          m_rv  = 1'b0;
  logic [DW-1:0] m_rd  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      m_rd  = '0;
    end else begin
      int n;
      n     = mq.size();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rv  = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        m_ovf = w_inc && (n == DEPTH);
        m_unf = r_inc && (n == 0);
        if (r_inc && n > 0) begin
          m_rd = mq.pop_front();
          exp_q.push_back(m_rd);
          m_rv = 1'b1;
        end
        if (w_inc && n < DEPTH) mq.push_back(wr_data);
      end
    end
  end

  // Monitor on the falling edge: scoreboard for registered reads, model compare for the rest.
  always @(negedge clk) begin
    int n;
    n = mq.size();
    chk("level_reg", 32'(r_level), 32'(n));
    chk("level_fw", 32'(f_level), 32'(n));
    chk("empty", 32'(r_empty), 32'(n == 0));
    chk("full", 32'(r_full), 32'(n == DEPTH));
    chk("almost_full", 32'(r_af), 32'(n >= DEPTH - 2));
    chk("almost_empty", 32'(r_ae), 32'(n <= 1));
    chk("overflow", 32'(r_ovf), 32'(m_ovf));
    chk("underflow", 32'(r_unf), 32'(m_unf));
    chk("overflow_fw", 32'(f_ovf), 32'(m_ovf));
    chk("underflow_fw", 32'(f_unf), 32'(m_unf));
    chk("rd_valid_reg", 32'(r_rd_valid), 32'(m_rv));
    chk("rd_data_hold", 32'(r_rd_data), 32'(m_rd));
    if (r_rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_nonempty", 32'(0), 32'(1));
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_rd_data_reg", 32'(r_rd_data), 32'(e));
      end
    end
    chk("rd_valid_fw", 32'(f_rd_valid), 32'(n > 0));
    if (n > 0) chk("rd_data_fw", 32'(f_rd_data), 32'(mq[0]));
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    w_inc   = w;
    wr_data = d;
    r_inc   = r;
    flush   = f;
    @(posedge clk);
    #1;
    w_inc = 1'b0;
    r_inc = 1'b0;
    flush = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_level"}, 32'(r_level), 32'(0));
    chk({tag, "_empty"}, 32'(r_empty), 32'(1));
    chk({tag, "_full"}, 32'(r_full), 32'(0));
    chk({tag, "_ae"}, 32'(r_ae), 32'(1));
    chk({tag, "_af"}, 32'(r_af), 32'(0));
    chk({tag, "_ovf"}, 32'(r_ovf), 32'(0));
    chk({tag, "_unf"}, 32'(r_unf), 32'(0));
    chk({tag, "_rv_reg"}, 32'(r_rd_valid), 32'(0));
    chk({tag, "_rd_reg"}, 32'(r_rd_data), 32'(0));
    chk({tag, "_rv_fw"}, 32'(f_rd_valid), 32'(0));
    chk({tag, "_level_fw"}, 32'(f_level), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] pat;
    rst_n   = 1'b0;
    flush   = 1'b0;
    w_inc   = 1'b0;
    r_inc   = 1'b0;
    wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Fill to full; almost-full first rises at level 14.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      chk("fill_af", 32'(r_af), 32'(i + 1 >= 14));
    end
    chk("fill_full", 32'(r_full), 32'(1));
    chk("fill_level16", 32'(r_level), 32'(16));
    cyc(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_pulse", 32'(r_ovf), 32'(1));
    chk("ovf_level", 32'(r_level), 32'(16));
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_clear", 32'(r_ovf), 32'(0));

    // Drain with registered reads.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_rv", 32'(r_rd_valid), 32'(1));
      chk("drain_data", 32'(r_rd_data), 32'(i));
    end
    chk("drain_empty", 32'(r_empty), 32'(1));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_pulse", 32'(r_unf), 32'(1));
    chk("unf_rd_hold", 32'(r_rd_data), 32'(8'h0F));
    chk("unf_rv", 32'(r_rd_valid), 32'(0));
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("unf_clear", 32'(r_unf), 32'(0));

    // Fall-through presentation of a single word.
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_data", 32'(f_rd_data), 32'(8'hA5));
    chk("fwft_valid", 32'(f_rd_valid), 32'(1));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_ack_empty", 32'(f_empty), 32'(1));
    chk("fwft_ack_valid", 32'(f_rd_valid), 32'(0));

    // Sustained simultaneous traffic at level 8.
    pat = 8'h40;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, pat, 1'b0, 1'b0);
      pat++;
    end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, pat, 1'b1, 1'b0);
      pat++;
      chk("stream_level", 32'(r_level), 32'(8));
    end

    // Drain to 5 and flush with both requests raised.
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_flush_level", 32'(r_level), 32'(5));
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_empty", 32'(r_empty), 32'(1));
    chk("flush_level", 32'(r_level), 32'(0));
    chk("flush_ovf", 32'(r_ovf), 32'(0));
    chk("flush_unf", 32'(r_unf), 32'(0));
    chk("flush_rv", 32'(r_rd_valid), 32'(0));

    // Reset mid-burst at level 9.
    for (int i = 0; i < 9; i++) cyc(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(r_level), 32'(9));
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    w_inc   = 1'b1;
    r_inc   = 1'b1;
    wr_data = 8'h55;
    rst_n   = 1'b0;
    #1;
    check_reset_outputs("midrst");
    w_inc = 1'b0;
    r_inc = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_fw", 32'(f_rd_data), 32'(8'h3C));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_reg", 32'(r_rd_data), 32'(8'h3C));
    chk("post_rst_rv", 32'(r_rd_valid), 32'(1));

    // Randomized traffic with phases biased toward full and toward empty.
    for (int i = 0; i < 3000; i++) begin
      int wp;
      wp = ((i / 200) % 2 == 0) ? 75 : 30;
      cyc(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
          DW'($urandom),
          ($urandom_range(0, 99) < (100 - wp)) ? 1'b1 : 1'b0,
          ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
# sync_fifo_fwft

Single-clock, parametrised FIFO buffer with first-word-fall-through or registered-read mode, programmable almost-full/almost-empty thresholds, occupancy count, synchronous flush and overflow/underflow error pulses. It is the same-clock-domain counterpart of the dual-clock FIFO. It is used wherever producer and consumer share one clock and need level-based flow control rather than bare full/empty flags.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDRESS_WIDTH, 4, address bits; DEPTH = 2**ADDRESS_WIDTH words
- FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through
- AF_THRESH, DEPTH-2, ALMOST_FULL asserts at FILL_LEVEL >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 1, ALMOST_EMPTY asserts at FILL_LEVEL <= AE_THRESH; legal range 0..DEPTH-1

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, asynchronous assert, active-low
- FLUSH  in  1  synchronous clear of all stored words
- W_INC  in  1  write request
- Wr_DATA  in  DATA_WIDTH  write data
- R_INC  in  1  read request
- Rd_DATA  out  DATA_WIDTH  read data
- Rd_VALID  out  1  Rd_DATA qualifier
- FULL  out  1  DEPTH words stored
- EMPTY  out  1  zero words stored
- ALMOST_FULL  out  1  threshold flag
- ALMOST_EMPTY  out  1  threshold flag
- FILL_LEVEL  out  ADDRESS_WIDTH+1  words stored, 0..DEPTH
- OVERFLOW  out  1  one-cycle pulse: a write was refused
- UNDERFLOW  out  1  one-cycle pulse: a read was refused

## Operation
- Storage is a DEPTH x DATA_WIDTH array with no reset.
- Write and read pointers are ADDRESS_WIDTH+1-bit binary counters. The low bits address the array; the MSB is the wrap bit. Pointers wrap naturally mod 2*DEPTH.
- EMPTY = (wptr == rptr). FULL = MSBs differ and low bits equal. FILL_LEVEL = wptr - rptr, mod 2**(ADDRESS_WIDTH+1). All three are combinational from registered pointers.
- Write accepted = W_INC & !FULL & !FLUSH: the array word at wptr is written and wptr increments.
- Read accepted = R_INC & !EMPTY & !FLUSH: rptr increments.
- Flag checks use the current-cycle FULL/EMPTY. A write on FULL is refused even with a concurrent accepted read. A read on EMPTY is refused even with a concurrent accepted write.
- Accepted read and write in the same cycle leave FILL_LEVEL unchanged.
- FLUSH has priority over W_INC/R_INC: both pointers go to 0 and no OVERFLOW/UNDERFLOW pulse is raised. Array contents are not cleared.
- FWFT=0:
  - On an accepted read, Rd_DATA is registered with mem[rptr] and Rd_VALID = 1 for the next cycle only.
  - Otherwise Rd_DATA holds its value and Rd_VALID = 0.
- FWFT=1:
  - Rd_DATA = mem[rptr] combinationally and Rd_VALID = !EMPTY.
  - R_INC acts as an acknowledge of the presented word.
- ALMOST_FULL = (FILL_LEVEL >= AF_THRESH). ALMOST_EMPTY = (FILL_LEVEL <= AE_THRESH). Both are combinational from FILL_LEVEL.
- OVERFLOW is registered: it is 1 in the cycle after W_INC & FULL & !FLUSH.
- UNDERFLOW is registered: it is 1 in the cycle after R_INC & EMPTY & !FLUSH.

## Timing
- Reset values while RST low: pointers 0, EMPTY=1, FULL=0, FILL_LEVEL=0, ALMOST_EMPTY=1, ALMOST_FULL=0 (AF_THRESH >= 1), OVERFLOW=0, UNDERFLOW=0, Rd_VALID=0, Rd_DATA=0 (FWFT=0). Rd_DATA in FWFT=1 is undefined while EMPTY.
- Assertion of RST mid-operation discards all content immediately. Release is synchronous to CLK; the first accepted operation is at the first rising edge with RST high.
- Write-to-flag latency: a write accepted at edge N updates EMPTY, FILL_LEVEL and the thresholds after edge N, visible in cycle N+1.
- FWFT=1: a word written at edge N into an empty FIFO appears on Rd_DATA with Rd_VALID=1 in cycle N+1.
- FWFT=0: a read accepted at edge N gives Rd_DATA/Rd_VALID after edge N, visible in cycle N+1.
- Full throughput is one write and one read per cycle sustained at any level 1..DEPTH-1.
- FLUSH at edge N gives EMPTY=1, FILL_LEVEL=0 in cycle N+1. A pending Rd_VALID (FWFT=0) from a read accepted at the same edge is not produced.

## Test plan
- Reset, then W_INC for 16 cycles with data 0x00..0x0F (DEPTH=16). Required: FULL=1 and FILL_LEVEL=16 after the 16th edge; ALMOST_FULL first high at FILL_LEVEL=14. A 17th write gives OVERFLOW=1 for one cycle and FILL_LEVEL stays 16.
- FWFT=0, FIFO holding 0x00..0x0F, R_INC for 16 cycles. Required: Rd_DATA 0x00..0x0F with Rd_VALID one cycle after each request. EMPTY=1 after the last read. A further R_INC gives UNDERFLOW=1 once and Rd_DATA holds 0x0F.
- FWFT=1, write 0xA5 into an empty FIFO. Required: Rd_DATA=0xA5 and Rd_VALID=1 the next cycle with no R_INC. R_INC one cycle gives EMPTY=1 and Rd_VALID=0 after.
- Simultaneous W_INC+R_INC for 40 cycles at FILL_LEVEL=8 with an incrementing pattern. Required: FILL_LEVEL constant 8, pointers wrap past 31, data order preserved, no error pulses.
- FILL_LEVEL=5, FLUSH with W_INC=R_INC=1. Required: EMPTY=1, FILL_LEVEL=0, no OVERFLOW/UNDERFLOW, and no Rd_VALID the next cycle.
- Assert RST low mid-burst at FILL_LEVEL=9. Required: all outputs at reset values immediately. After release, the first write of 0x3C is read back as 0x3C.
